// File: rtl/spi_regslave_pkg.sv
// Shared types and constants for the SPI register slave.
// Optional frame counter is enabled by SPI_REGSLAVE_FRAMECNT_EN (see spi_regslave.sv).
package spi_regslave_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2
    } state_e;

    // Number of flops in each pin synchroniser.
    localparam int unsigned SyncStages = 2;

    // The command word carries the write flag in its MSB.
    function automatic int unsigned wr_flag_pos(input int unsigned width);
        return width - 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with edge pulses derived
// from the synchronised level.
module spi_sync
    import spi_regslave_pkg::*;
#(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SyncStages{ResetVal}};
            prev_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], d};
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign q    = sync_q[SyncStages-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_regslave.sv
// SPI slave with a small register file, burst auto-increment and read-back.
// Define SPI_REGSLAVE_FRAMECNT_EN to return a transaction count instead of ID.
module spi_regslave
    import spi_regslave_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      AW    = 2,
    parameter bit               CPOL  = 1'b0,
    parameter bit               CPHA  = 1'b0,
    parameter logic [WIDTH-1:0] ID    = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ss_n,
    input  logic                        sclk,
    input  logic                        mosi,
    output logic                        miso,
    output logic                        miso_oe,
    output logic [(2**AW)*WIDTH-1:0]    regs,
    output logic                        wr_strobe,
    output logic [AW-1:0]               wr_addr
);

    localparam int unsigned NREGS   = 2 ** AW;
    localparam int unsigned BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned WrFlag  = wr_flag_pos(WIDTH);
    localparam logic [BW-1:0] LastBit = BW'(WIDTH - 1);

    // Pin synchronisers
    logic sclk_q, sclk_rise, sclk_fall;
    logic ss_q, ss_rise, ss_fall;
    logic unused_sclk_level;

    spi_sync #(.ResetVal(CPOL)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Reset low so a pin held low across reset never looks like a fresh select.
    spi_sync #(.ResetVal(1'b0)) u_ss_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ss_n),
        .q    (ss_q),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign unused_sclk_level = sclk_q;

    logic [SyncStages-1:0] mosi_sync_q;
    logic                  mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SyncStages-1];

    // Edge decode
    logic lead_edge, trail_edge, sample_edge, shift_edge;

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // Datapath and control state
    state_e           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] tx_q;
    logic [AW-1:0]    addr_q;
    logic             write_q;
    logic             armed_q;
    logic [WIDTH-1:0] reg_q [NREGS];

    logic [WIDTH-1:0] rx_next;
    logic [AW-1:0]    cmd_addr;
    logic [AW-1:0]    addr_inc;
    logic             last_bit;
    logic             cmd_done;
    logic [WIDTH-1:0] cmd_word;

    assign rx_next  = {rx_q[WIDTH-2:0], mosi_s};
    assign cmd_addr = rx_next[AW-1:0];
    assign addr_inc = addr_q + 1'b1;
    assign last_bit = (bit_cnt_q == LastBit);
    assign cmd_done = (state_q == StCmd) && sample_edge && last_bit;

`ifdef SPI_REGSLAVE_FRAMECNT_EN
    logic [WIDTH-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (cmd_done) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign cmd_word = frame_cnt_q;
`else
    assign cmd_word = ID;
`endif

    // Bus is ignored after reset until ss_n has been seen high.
    assign miso_oe = armed_q & ~ss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            armed_q   <= 1'b0;
            miso      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int k = 0; k < NREGS; k++) begin
                reg_q[k] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (ss_q) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (armed_q && ss_fall) begin
                        state_q   <= StCmd;
                        bit_cnt_q <= '0;
                        rx_q      <= '0;
                        // CPHA=0 must present the first bit before any sclk edge.
                        if (!CPHA) begin
                            miso <= cmd_word[WIDTH-1];
                            tx_q <= {cmd_word[WIDTH-2:0], 1'b0};
                        end else begin
                            tx_q <= cmd_word;
                        end
                    end
                end

                StCmd, StData: begin
                    if (shift_edge) begin
                        miso <= tx_q[WIDTH-1];
                        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                    end
                    if (sample_edge) begin
                        rx_q      <= rx_next;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            if (state_q == StCmd) begin
                                state_q <= StData;
                                write_q <= rx_next[WrFlag];
                                addr_q  <= cmd_addr;
                                tx_q    <= reg_q[cmd_addr];
                            end else begin
                                if (write_q) begin
                                    reg_q[addr_q] <= rx_next;
                                    wr_strobe     <= 1'b1;
                                    wr_addr       <= addr_q;
                                end
                                addr_q <= addr_inc;
                                tx_q   <= reg_q[addr_inc];
                            end
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase

            // Deselect wins over everything except a frame finishing this cycle.
            if (state_q != StIdle && ss_rise) begin
                state_q <= StIdle;
            end
        end
    end

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        assign regs[k*WIDTH +: WIDTH] = reg_q[k];
    end

endmodule

// File: tb/tb_spi_regslave.sv
// Directed bench for spi_regslave: a mode 0 and a mode 3 instance on a shared bus.
module tb_spi_regslave;

`ifdef SPI_REGSLAVE_FRAMECNT_EN
    localparam bit FRAMECNT = 1'b1;
`else
    localparam bit FRAMECNT = 1'b0;
`endif
    localparam time HALF = 40ns;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss0 = 1'b1;
    logic        ss3 = 1'b1;
    logic        miso0, oe0, strb0;
    logic        miso3, oe3, strb3;
    logic [31:0] regs0, regs3;
    logic [1:0]  waddr0, waddr3;

    int          vectors = 0;
    int          miscompares = 0;
    int          ns0 = 0;
    int          ns3 = 0;
    logic [1:0]  sa0 [$];
    logic [1:0]  sa3 [$];
    int          b0, b3;
    int          seq0 = 0;
    int          seq3 = 0;
    logic [7:0]  rxb;

    always #5 clk = ~clk;

    spi_regslave #(.WIDTH(8), .AW(2), .CPOL(1'b0), .CPHA(1'b0), .ID(8'hA5)) u_m0 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss0), .sclk(sclk), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .regs(regs0), .wr_strobe(strb0), .wr_addr(waddr0)
    );

    spi_regslave #(.WIDTH(8), .AW(2), .CPOL(1'b1), .CPHA(1'b1), .ID(8'hA5)) u_m3 (
        .clk(clk), .rst_n(rst_n), .ss_n(ss3), .sclk(sclk), .mosi(mosi),
        .miso(miso3), .miso_oe(oe3), .regs(regs3), .wr_strobe(strb3), .wr_addr(waddr3)
    );

    always @(negedge clk) begin
        if (strb0) begin
            ns0 <= ns0 + 1;
            sa0.push_back(waddr0);
        end
        if (strb3) begin
            ns3 <= ns3 + 1;
            sa3.push_back(waddr3);
        end
    end

    function automatic logic [7:0] cmd_exp(input int n);
        return FRAMECNT ? 8'(n) : 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_tx(input bit m3);
        sclk = m3;
        #HALF;
        if (m3) ss3 = 1'b0;
        else    ss0 = 1'b0;
        #(2 * HALF);
    endtask

    task automatic end_tx(input bit m3);
        #HALF;
        if (m3) ss3 = 1'b1;
        else    ss0 = 1'b1;
        #(4 * HALF);
    endtask

    // Master side: shift on one edge, sample MISO just before the sample edge.
    task automatic xfer(input bit m3, input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (m3) begin
                sclk = 1'b0;
                mosi = tx[7-i];
                #HALF;
                rx = {rx[6:0], miso3};
                sclk = 1'b1;
                #HALF;
            end else begin
                mosi = tx[7-i];
                #HALF;
                rx = {rx[6:0], miso0};
                sclk = 1'b1;
                #HALF;
                sclk = 1'b0;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: observed no finish, expected finish before 2ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        #33ns;
        chk("rst_regs0", regs0, 32'h0);
        chk("rst_miso0", {31'h0, miso0}, 32'h0);
        chk("rst_oe0", {31'h0, oe0}, 32'h0);
        chk("rst_strb0", {31'h0, strb0}, 32'h0);
        chk("rst_waddr0", {30'h0, waddr0}, 32'h0);
        rst_n = 1'b1;
        #100ns;

        // Single write
        b0 = ns0;
        begin_tx(1'b0);
        chk("oe0_active", {31'h0, oe0}, 32'h1);
        xfer(1'b0, 8'h81, 8, rxb);
        chk("wr_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq0++)});
        xfer(1'b0, 8'h3C, 8, rxb);
        end_tx(1'b0);
        chk("oe0_idle", {31'h0, oe0}, 32'h0);
        chk("wr_regs", regs0, 32'h0000_3C00);
        chk("wr_nstrobe", ns0 - b0, 1);
        chk("wr_addr", {30'h0, sa0[b0]}, 32'h1);

        // Read-back
        b0 = ns0;
        begin_tx(1'b0);
        xfer(1'b0, 8'h01, 8, rxb);
        chk("rd_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq0++)});
        xfer(1'b0, 8'h00, 8, rxb);
        chk("rd_data", {24'h0, rxb}, 32'h3C);
        end_tx(1'b0);
        chk("rd_nstrobe", ns0 - b0, 0);

        // Burst write wrapping 3 -> 0
        b0 = ns0;
        begin_tx(1'b0);
        xfer(1'b0, 8'h83, 8, rxb);
        chk("bw_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq0++)});
        xfer(1'b0, 8'h11, 8, rxb);
        xfer(1'b0, 8'h22, 8, rxb);
        end_tx(1'b0);
        chk("bw_regs", regs0, 32'h1100_3C22);
        chk("bw_nstrobe", ns0 - b0, 2);
        chk("bw_addr_a", {30'h0, sa0[b0]}, 32'h3);
        chk("bw_addr_b", {30'h0, sa0[b0+1]}, 32'h0);

        // Burst read wrapping 3 -> 0
        begin_tx(1'b0);
        xfer(1'b0, 8'h03, 8, rxb);
        seq0++;
        xfer(1'b0, 8'h00, 8, rxb);
        chk("br_data3", {24'h0, rxb}, 32'h11);
        xfer(1'b0, 8'h00, 8, rxb);
        chk("br_data0", {24'h0, rxb}, 32'h22);
        end_tx(1'b0);

        // Abort mid-frame, then a complete write to the same register
        b0 = ns0;
        begin_tx(1'b0);
        xfer(1'b0, 8'h82, 8, rxb);
        seq0++;
        xfer(1'b0, 8'hF0, 4, rxb);
        end_tx(1'b0);
        chk("ab_regs", regs0, 32'h1100_3C22);
        chk("ab_nstrobe", ns0 - b0, 0);
        b0 = ns0;
        begin_tx(1'b0);
        xfer(1'b0, 8'h82, 8, rxb);
        chk("ab2_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq0++)});
        xfer(1'b0, 8'h55, 8, rxb);
        end_tx(1'b0);
        chk("ab2_regs", regs0, 32'h1155_3C22);
        chk("ab2_nstrobe", ns0 - b0, 1);
        chk("ab2_addr", {30'h0, sa0[b0]}, 32'h2);

        // Reset mid-frame; bus must be ignored until ss_n goes high
        b0 = ns0;
        begin_tx(1'b0);
        xfer(1'b0, 8'h81, 8, rxb);
        xfer(1'b0, 8'h77, 4, rxb);
        rst_n = 1'b0;
        #20ns;
        chk("mr_regs", regs0, 32'h0);
        chk("mr_oe", {31'h0, oe0}, 32'h0);
        chk("mr_strb", {31'h0, strb0}, 32'h0);
        rst_n = 1'b1;
        seq0 = 0;
        xfer(1'b0, 8'h07, 4, rxb);
        chk("mr_oe_ignored", {31'h0, oe0}, 32'h0);
        end_tx(1'b0);
        chk("mr_regs_after", regs0, 32'h0);
        chk("mr_nstrobe", ns0 - b0, 0);
        begin_tx(1'b0);
        xfer(1'b0, 8'h81, 8, rxb);
        chk("mr_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq0++)});
        xfer(1'b0, 8'h3C, 8, rxb);
        end_tx(1'b0);
        chk("mr_wr_regs", regs0, 32'h0000_3C00);
        chk("mr_wr_nstrobe", ns0 - b0, 1);

        // Mode 3 instance: write then read back
        chk("m3_idle_regs", regs3, 32'h0);
        b3 = ns3;
        begin_tx(1'b1);
        chk("m3_oe_active", {31'h0, oe3}, 32'h1);
        xfer(1'b1, 8'h81, 8, rxb);
        chk("m3_wr_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq3++)});
        xfer(1'b1, 8'h3C, 8, rxb);
        end_tx(1'b1);
        chk("m3_wr_regs", regs3, 32'h0000_3C00);
        chk("m3_wr_nstrobe", ns3 - b3, 1);
        chk("m3_wr_addr", {30'h0, sa3[b3]}, 32'h1);
        b3 = ns3;
        begin_tx(1'b1);
        xfer(1'b1, 8'h01, 8, rxb);
        chk("m3_rd_cmd_miso", {24'h0, rxb}, {24'h0, cmd_exp(seq3++)});
        xfer(1'b1, 8'h00, 8, rxb);
        chk("m3_rd_data", {24'h0, rxb}, 32'h3C);
        end_tx(1'b1);
        chk("m3_rd_nstrobe", ns3 - b3, 0);
        chk("m0_untouched", regs0, 32'h0000_3C00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
